tuner_indicator: RTL and testbench

Downstream display stage of the tuner: consumes each peak/note result from the frequency finder (`did_find`, `note`, `difference`), smooths the cents-like offset over a short window per string, and drives a 7-segment note letter, a 9-LED flat/sharp bar and an in-tune LED. Results tagged as "no peak" are discarded. The display blanks itself after a timeout with no accepted result.

---
 rtl/tuner_indicator_if.sv | 21 ++
 rtl/tuner_indicator.sv | 169 ++++++++++++++++
 tb/tb_tuner_indicator.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tuner_indicator_if.sv
// Result bus from the frequency finder into the tuner display stage, plus the
// display outputs. The finder/bench side is master, the display stage is slave.
interface tuner_indicator_if;
    logic              did_find;
    logic [2:0]        note;
    logic signed [9:0] difference;
    logic [6:0]        seg;
    logic [8:0]        led_bar;
    logic              in_tune;
    logic              valid;

    modport master (
        output did_find, note, difference,
        input  seg, led_bar, in_tune, valid
    );

    modport slave (
        input  did_find, note, difference,
        output seg, led_bar, in_tune, valid
    );
endinterface

// File: rtl/tuner_indicator.sv
// Tuner display stage: per-string moving average of the finder offset, rendered
// as a 7-segment note letter, a one-hot flat/sharp bar and an in-tune LED.
module tuner_indicator #(
    parameter int AVG_LOG2       = 2,
    parameter int TOL            = 1,
    parameter int STEP_LOG2      = 2,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int NO_PEAK        = 511
) (
    input  logic              clk,
    input  logic              rst_n,
    tuner_indicator_if.slave  bus
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = 10 + AVG_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [9:0] NO_PEAK_V = 10'(NO_PEAK);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_BLANK  = 2'd0;
    localparam logic [1:0] S_UPDATE = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_SHOW   = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_G     = 7'b1000010;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [1:0]              state_reg;
    logic                    did_find_reg;
    logic                    from_blank_reg;
    logic [2:0]              note_lat_reg;
    logic [2:0]              last_note_reg;
    logic signed [9:0]       diff_lat_reg;
    logic signed [9:0]       win_reg [DEPTH];
    logic signed [SUM_W-1:0] sum_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [6:0]              seg_reg;
    logic [8:0]              led_reg;
    logic                    tune_reg;
    logic                    valid_reg;

    logic                    sample_edge;
    logic                    accept;
    logic                    flush;
    logic signed [SUM_W-1:0] new_ext;
    logic signed [SUM_W-1:0] old_ext;
    logic signed [10:0]      avg_ext;
    logic [10:0]             mag;
    logic [10:0]             steps;
    logic [2:0]              level;
    logic [3:0]              bar_idx;
    logic                    tune_next;
    logic [8:0]              bar_next;
    logic [6:0]              seg_next;

    assign sample_edge = bus.did_find & ~did_find_reg;
    assign accept      = sample_edge && (bus.difference != NO_PEAK_V) &&
                         (state_reg == S_BLANK || state_reg == S_SHOW);
    // A new string or a return from blank restarts the average from scratch.
    assign flush       = from_blank_reg || (note_lat_reg != last_note_reg);
    assign new_ext     = SUM_W'(diff_lat_reg);
    assign old_ext     = SUM_W'(win_reg[DEPTH-1]);

    always_comb begin
        avg_ext   = 11'(sum_reg >>> AVG_LOG2);
        mag       = avg_ext[10] ? 11'(-avg_ext) : 11'(avg_ext);
        steps     = (mag - 11'(TOL) - 11'd1) >> STEP_LOG2;
        level     = (steps >= 11'd4) ? 3'd4 : 3'(steps) + 3'd1;
        tune_next = (mag <= 11'(TOL));
        // Positive offset means flat, which lights the low end of the bar.
        if (tune_next)
            bar_idx = 4'd4;
        else if (avg_ext > 0)
            bar_idx = 4'd4 - {1'b0, level};
        else
            bar_idx = 4'd4 + {1'b0, level};
        bar_next = 9'd1 << bar_idx;
        case (note_lat_reg)
            3'd0, 3'd5: seg_next = SEG_E;
            3'd1:       seg_next = SEG_A;
            3'd2:       seg_next = SEG_D;
            3'd3:       seg_next = SEG_G;
            3'd4:       seg_next = SEG_B;
            default:    seg_next = SEG_DASH;
        endcase
    end

    // Window entry 0 holds the newest sample, entry DEPTH-1 the oldest.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_win
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    win_reg[gi] <= '0;
                end else if (state_reg == S_UPDATE) begin
                    if (flush)
                        win_reg[gi] <= diff_lat_reg;
                    else if (gi == 0)
                        win_reg[gi] <= diff_lat_reg;
                    else
                        win_reg[gi] <= win_reg[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_BLANK;
            did_find_reg   <= 1'b0;
            from_blank_reg <= 1'b0;
            note_lat_reg   <= '0;
            last_note_reg  <= '0;
            diff_lat_reg   <= '0;
            sum_reg        <= '0;
            cnt_reg        <= '0;
            seg_reg        <= SEG_BLANK;
            led_reg        <= '0;
            tune_reg       <= 1'b0;
            valid_reg      <= 1'b0;
        end else begin
            did_find_reg <= bus.did_find;
            case (state_reg)
                S_BLANK, S_SHOW: begin
                    if (accept) begin
                        note_lat_reg   <= bus.note;
                        diff_lat_reg   <= bus.difference;
                        from_blank_reg <= (state_reg == S_BLANK);
                        state_reg      <= S_UPDATE;
                    end else if (state_reg == S_SHOW) begin
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= S_BLANK;
                            seg_reg   <= SEG_BLANK;
                            led_reg   <= '0;
                            tune_reg  <= 1'b0;
                            valid_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                end
                S_UPDATE: begin
                    last_note_reg <= note_lat_reg;
                    sum_reg       <= flush ? (new_ext <<< AVG_LOG2)
                                           : (sum_reg + new_ext - old_ext);
                    state_reg     <= S_DECODE;
                end
                S_DECODE: begin
                    seg_reg   <= seg_next;
                    led_reg   <= bar_next;
                    tune_reg  <= tune_next;
                    valid_reg <= 1'b1;
                    cnt_reg   <= '0;
                    state_reg <= S_SHOW;
                end
                default: state_reg <= S_BLANK;
            endcase
        end
    end

    assign bus.seg     = seg_reg;
    assign bus.led_bar = led_reg;
    assign bus.in_tune = tune_reg;
    assign bus.valid   = valid_reg;
endmodule

// File: tb/tb_tuner_indicator.sv
// Scoreboard bench for tuner_indicator: each driven result queues its expected
// display state with the cycle it must appear; a negedge monitor pops and compares.
module tb_tuner_indicator;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    tuner_indicator_if bus ();

    tuner_indicator #(
        .AVG_LOG2(2), .TOL(1), .STEP_LOG2(2), .TIMEOUT_CYCLES(TMO), .NO_PEAK(511)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      tag;
        logic [6:0] seg;
        logic [8:0] led;
        logic       tune;
        logic       vld;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [6:0] s, input int idx, input logic t);
        exp_t e;
        e.due  = 0;
        e.tag  = tag;
        e.seg  = s;
        e.led  = (idx < 0) ? 9'd0 : 9'(1 << idx);
        e.tune = t;
        e.vld  = (idx >= 0);
        return e;
    endfunction

    task automatic send(input logic [2:0] n, input logic signed [9:0] d, input int hold,
                        input bit push, input exp_t e, output int due);
        @(negedge clk);
        bus.did_find   = 1'b1;
        bus.note       = n;
        bus.difference = d;
        due   = cyc + 3;
        e.due = due;
        if (push) sb.push_back(e);
        repeat (hold) @(negedge clk);
        bus.did_find = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due < cyc) begin
                check({mon_e.tag, "_late"}, 32'(cyc), 32'(mon_e.due));
            end else begin
                $display("txn %-10s cyc=%0d seg=%b led=%b tune=%b valid=%b", mon_e.tag, cyc,
                         bus.seg, bus.led_bar, bus.in_tune, bus.valid);
                check({mon_e.tag, "_seg"},   32'(bus.seg),     32'(mon_e.seg));
                check({mon_e.tag, "_led"},   32'(bus.led_bar), 32'(mon_e.led));
                check({mon_e.tag, "_tune"},  32'(bus.in_tune), 32'(mon_e.tune));
                check({mon_e.tag, "_valid"}, 32'(bus.valid),   32'(mon_e.vld));
            end
        end
    end

    localparam logic [6:0] E_ = 7'b0000110, A_ = 7'b0001000, D_ = 7'b0100001;
    localparam logic [6:0] G_ = 7'b1000010, B_ = 7'b0000011, DASH = 7'b0111111, BLK = 7'b1111111;

    initial begin
        int due;
        int d_hold;
        rst_n          = 1'b0;
        bus.did_find   = 1'b0;
        bus.note       = 3'd0;
        bus.difference = 10'sd0;
        repeat (2) @(negedge clk);
        check("rst_seg",   32'(bus.seg),     32'(BLK));
        check("rst_led",   32'(bus.led_bar), 32'd0);
        check("rst_tune",  32'(bus.in_tune), 32'd0);
        check("rst_valid", 32'(bus.valid),   32'd0);
        rst_n = 1'b1;

        send(3'd1,  10'sd0,   1, 1'b1, mk("a_zero", A_, 4, 1'b1), due);
        send(3'd3,  10'sd8,   1, 1'b1, mk("g_8a",   G_, 2, 1'b0), due);
        send(3'd3,  10'sd8,   1, 1'b1, mk("g_8b",   G_, 2, 1'b0), due);
        send(3'd3,  10'sd0,   1, 1'b1, mk("g_0a",   G_, 2, 1'b0), due);
        send(3'd3,  10'sd0,   1, 1'b1, mk("g_0b",   G_, 3, 1'b0), due);
        send(3'd4, -10'sd20,  1, 1'b1, mk("b_m20",  B_, 8, 1'b0), due);
        send(3'd4, -10'sd5,   1, 1'b1, mk("b_m5",   B_, 8, 1'b0), due);
        send(3'd4,  10'sd511, 1, 1'b1, mk("nopeak", B_, 8, 1'b0), due);
        send(3'd6,  10'sd1,   1, 1'b1, mk("dash_1", DASH, 4, 1'b1), due);
        send(3'd0, -10'sd2,   1, 1'b1, mk("e_m2",   E_, 5, 1'b0), due);
        send(3'd5,  10'sd2,   1, 1'b1, mk("e5_2",   E_, 3, 1'b0), due);
        send(3'd2,  10'sd100, 1, 1'b1, mk("d_100",  D_, 0, 1'b0), due);

        // Held strobe is a single sample: window {-100,100,100,100}, avg 50.
        send(3'd2, -10'sd100, 3, 1'b1, mk("d_hold", D_, 0, 1'b0), d_hold);
        mon_e     = mk("tmo_hold", D_, 0, 1'b0);
        mon_e.due = d_hold + TMO - 1;
        sb.push_back(mon_e);
        mon_e     = mk("tmo_blank", BLK, -1, 1'b0);
        mon_e.due = d_hold + TMO;
        sb.push_back(mon_e);
        repeat (4) send(3'd2, 10'sd511, 1, 1'b0, mon_e, due);
        while (cyc < d_hold + TMO + 2) @(negedge clk);

        // Same note after blank must still start a fresh window.
        send(3'd2, 10'sd8, 1, 1'b1, mk("d_fresh", D_, 2, 1'b0), due);

        @(negedge clk);
        bus.did_find   = 1'b1;
        bus.note       = 3'd1;
        bus.difference = 10'sd0;
        @(negedge clk);
        rst_n        = 1'b0;
        bus.did_find = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_seg",   32'(bus.seg),   32'(BLK));
        check("midrst_valid", 32'(bus.valid), 32'd0);
        repeat (5) @(negedge clk);
        check("midrst_seg2",   32'(bus.seg),   32'(BLK));
        check("midrst_valid2", 32'(bus.valid), 32'd0);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
